// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS32 datapath: PC, IR, MDR, A, B, ALUOut, 32x32 register
// file and ALU, steered cycle by cycle by an external control FSM. Drives a
// unified instruction/data memory with combinational read data.
//
// Optional build macro: ZERO_EXT_LOGIC_IMM_EN
//   defined   -> ori/xori zero-extend their 16-bit immediate
//   undefined -> every immediate is sign-extended
module mips_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg,
  input  logic        RegDst,
  input  logic        IorD,
  input  logic        AluSrcA,
  input  logic        IRWrite,
  input  logic        MemWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        BranchNE,
  input  logic        RegWrite,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  AluSrcB,
  input  logic [2:0]  AluControl,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] pc_q;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic [31:0] rf [32];

  logic [31:0] imm;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] pc_next;
  logic [31:0] jump_target;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wr_data;
  logic [4:0]  wr_addr;
  logic        pc_en;

  assign Op        = ir[31:26];
  assign Funct     = ir[5:0];
  assign pc        = pc_q;
  assign mem_addr  = IorD ? alu_out : pc_q;
  assign mem_wdata = b_reg;
  assign mem_we    = MemWrite;

  // Register $0 reads as zero regardless of array contents.
  assign rs_data  = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
  assign rt_data  = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];
  assign dbg_data = (dbg_addr == 5'd0)  ? 32'd0 : rf[dbg_addr];

  assign wr_addr = RegDst   ? ir[15:11] : ir[20:16];
  assign wr_data = MemtoReg ? mdr       : alu_out;

  // PC already holds PC+4 by the time a jump executes.
  assign jump_target = {pc_q[31:28], ir[25:0], 2'b00};

`ifdef ZERO_EXT_LOGIC_IMM_EN
  // Immediate: ori/xori zero-extend, everything else sign-extends.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    imm = {{16{ir[15]}}, ir[15:0]};
    if (ir[31:26] == 6'b001101 || ir[31:26] == 6'b001110) begin
      imm = {16'd0, ir[15:0]};
    end
  end
`else
  assign imm = {{16{ir[15]}}, ir[15:0]};
`endif

  // ALU operand selection.
  always_comb begin
    src_a = AluSrcA ? a_reg : pc_q;
    src_b = b_reg;
    case (AluSrcB)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = imm;
      default: src_b = {imm[29:0], 2'b00};
    endcase
  end

  // ALU: modulo arithmetic, signed slt, unused encodings yield zero.
  always_comb begin
    alu_result = 32'd0;
    case (AluControl)
      3'b010:  alu_result = src_a + src_b;
      3'b110:  alu_result = src_a - src_b;
      3'b000:  alu_result = src_a & src_b;
      3'b001:  alu_result = src_a | src_b;
      3'b011:  alu_result = src_a ^ src_b;
      3'b100:  alu_result = ~(src_a | src_b);
      3'b111:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // Next-PC selection and PC enable (unconditional or beq/bne outcome).
  always_comb begin
    pc_en = PCWrite | (Branch & ~BranchNE & zero) | (Branch & BranchNE & ~zero);
    case (PCSrc)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = jump_target;
      default: pc_next = pc_q;
    endcase
  end

  // Architectural and inter-cycle registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pc_q    <= RESET_PC;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
    end else begin
      mdr     <= mem_rdata;
      a_reg   <= rs_data;
      b_reg   <= rt_data;
      alu_out <= alu_result;
      if (IRWrite) ir   <= mem_rdata;
      if (pc_en)   pc_q <= pc_next;
    end
  end

  // Register file write port; no bypass, so A/B capture the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is architecturally cleared on reset, so this array is not inferred as RAM.
      for (int i = 0; i < 32; i++) begin
        rf[i] <= 32'd0;
      end
    end else if (RegWrite && wr_addr != 5'd0) begin
      rf[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Directed-vector bench for mips_multicycle_datapath. The stimulus process
// plays the control FSM and pushes hand-computed expectations into a
// scoreboard queue; a monitor process pops and compares on the falling edge.
module tb_mips_multicycle_datapath;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dst;
    logic       ior_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       reg_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
  } ctrl_t;

  typedef enum {K_PC, K_ADDR, K_OP, K_FUNCT, K_REG} kind_t;

  typedef struct {
    kind_t       kind;
    logic [4:0]  addr;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        rst;
  ctrl_t       c;
  logic [31:0] mem_rdata;
  logic [4:0]  dbg_addr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] pc;
  logic [31:0] dbg_data;

  chk_t sb_q[$];
  int   total;
  int   bad;

`ifdef ZERO_EXT_LOGIC_IMM_EN
  localparam logic [31:0] ORI_EXP = 32'h0000_8001;
`else
  localparam logic [31:0] ORI_EXP = 32'hFFFF_8001;
`endif

  mips_multicycle_datapath #(.RESET_PC(32'h0000_0100)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemtoReg  (c.mem_to_reg),
    .RegDst    (c.reg_dst),
    .IorD      (c.ior_d),
    .AluSrcA   (c.alu_src_a),
    .IRWrite   (c.ir_write),
    .MemWrite  (c.mem_write),
    .PCWrite   (c.pc_write),
    .Branch    (c.branch),
    .BranchNE  (c.branch_ne),
    .RegWrite  (c.reg_write),
    .PCSrc     (c.pc_src),
    .AluSrcB   (c.alu_src_b),
    .AluControl(c.alu_ctl),
    .Op        (op),
    .Funct     (funct),
    .zero      (zero),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue an expectation for the monitor.
  task automatic push(input kind_t kind, input logic [4:0] addr,
                      input logic [31:0] exp, input string name);
    chk_t e;
    e.kind = kind;
    e.addr = addr;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Apply one cycle of control strobes, then return to idle.
  task automatic step(input ctrl_t s);
    c = s;
    @(posedge clk);
    #1;
    c = '0;
  endtask

  // Idle until the monitor has consumed every queued expectation.
  task automatic drain();
    c = '0;
    for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic fetch(input logic [31:0] instr);
    ctrl_t s;
    s = '0;
    s.alu_src_b = 2'b01;
    s.alu_ctl   = 3'b010;
    s.ir_write  = 1'b1;
    s.pc_write  = 1'b1;
    mem_rdata   = instr;
    step(s);
  endtask

  // Decode: A/B capture, ALUOut <= PC + (Imm << 2).
  task automatic decode();
    ctrl_t s;
    s = '0;
    s.alu_src_b = 2'b11;
    s.alu_ctl   = 3'b010;
    step(s);
  endtask

  task automatic exec_alu(input logic [1:0] b_sel, input logic [2:0] ctl);
    ctrl_t s;
    s = '0;
    s.alu_src_a = 1'b1;
    s.alu_src_b = b_sel;
    s.alu_ctl   = ctl;
    step(s);
  endtask

  task automatic writeback(input logic reg_dst, input logic mem_to_reg);
    ctrl_t s;
    s = '0;
    s.reg_write  = 1'b1;
    s.reg_dst    = reg_dst;
    s.mem_to_reg = mem_to_reg;
    step(s);
  endtask

  // Full R-type (rd) or I-type (rt) ALU instruction, then queue the result check.
  task automatic alu_instr(input logic [31:0] instr, input logic rtype,
                           input logic [2:0] ctl, input logic [4:0] dst,
                           input logic [31:0] exp, input string name);
    fetch(instr);
    decode();
    exec_alu(rtype ? 2'b00 : 2'b10, ctl);
    writeback(rtype, 1'b0);
    push(K_REG, dst, exp, name);
    drain();
  endtask

  // Load-style sequence: MDR captures data, then written to rt.
  task automatic load(input logic [31:0] instr, input logic [31:0] data);
    fetch(instr);
    decode();
    mem_rdata = data;
    step('0);
    writeback(1'b0, 1'b1);
  endtask

  // Monitor: pops expectations on the falling edge and compares.
  initial begin
    chk_t        e;
    logic [31:0] act;
    dbg_addr = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3 && sb_q.size() > 0; k++) begin
        e = sb_q.pop_front();
        dbg_addr = e.addr;
        #1;
        case (e.kind)
          K_PC:    act = pc;
          K_ADDR:  act = mem_addr;
          K_OP:    act = {26'd0, op};
          K_FUNCT: act = {26'd0, funct};
          default: act = dbg_data;
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    ctrl_t s;
    total     = 0;
    bad       = 0;
    c         = '0;
    mem_rdata = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    push(K_PC, 5'd0, 32'h0000_0100, "reset_pc");
    push(K_ADDR, 5'd0, 32'h0000_0100, "reset_mem_addr");
    push(K_OP, 5'd0, 32'd0, "reset_op");
    push(K_FUNCT, 5'd0, 32'd0, "reset_funct");
    for (int r = 0; r < 32; r++) push(K_REG, 5'(r), 32'd0, "reset_reg");
    drain();

    // addi $8,$0,5 with fetch checks.
    fetch(32'h2008_0005);
    push(K_PC, 5'd0, 32'h0000_0104, "fetch_pc");
    push(K_OP, 5'd0, 32'h0000_0008, "fetch_op");
    decode();
    exec_alu(2'b10, 3'b010);
    writeback(1'b0, 1'b0);
    push(K_REG, 5'd8, 32'd5, "addi_r8");
    push(K_ADDR, 5'd0, 32'h0000_0104, "mem_addr_pc");
    drain();

    alu_instr(32'h2009_0007, 1'b0, 3'b010, 5'd9, 32'd7, "addi_r9");

    // sub $10,$8,$9 with a funct check.
    fetch(32'h0109_5022);
    push(K_FUNCT, 5'd0, 32'h0000_0022, "sub_funct");
    decode();
    exec_alu(2'b00, 3'b110);
    writeback(1'b1, 1'b0);
    push(K_REG, 5'd10, 32'hFFFF_FFFE, "sub_r10");
    drain();

    alu_instr(32'h0109_582A, 1'b1, 3'b111, 5'd11, 32'd1, "slt_r11");
    alu_instr(32'h0109_7826, 1'b1, 3'b011, 5'd15, 32'd2, "xor_r15");
    alu_instr(32'h0109_8027, 1'b1, 3'b100, 5'd16, 32'hFFFF_FFF8, "nor_r16");

    // beq $8,$8,3 at 0x118: taken to 0x11C + 12.
    fetch(32'h1108_0003);
    decode();
    s = '0;
    s.alu_src_a = 1'b1;
    s.alu_ctl   = 3'b110;
    s.branch    = 1'b1;
    s.pc_src    = 2'b01;
    step(s);
    push(K_PC, 5'd0, 32'h0000_0128, "beq_taken_pc");
    drain();

    // Same encoding as bne: equal operands, not taken.
    fetch(32'h1108_0003);
    decode();
    s.branch_ne = 1'b1;
    step(s);
    push(K_PC, 5'd0, 32'h0000_012C, "bne_not_taken_pc");
    drain();

    // MDR path into $12, then the same data aimed at $0.
    load(32'h8C0C_0000, 32'hDEAD_BEEF);
    push(K_REG, 5'd12, 32'hDEAD_BEEF, "load_r12");
    writeback(1'b1, 1'b1);
    push(K_REG, 5'd0, 32'd0, "write_r0_ignored");
    drain();

    // Load $13 = 0x1000_0000 and jump-register through the ALU.
    load(32'h8C0D_0000, 32'h1000_0000);
    fetch(32'h01A0_0008);
    decode();
    s = '0;
    s.alu_src_a = 1'b1;
    s.alu_ctl   = 3'b010;
    s.pc_write  = 1'b1;
    step(s);
    push(K_PC, 5'd0, 32'h1000_0000, "jr_pc");
    drain();

    // j with IR[25:0]=0x40 from 0x1000_0004.
    fetch(32'h0800_0040);
    push(K_PC, 5'd0, 32'h1000_0004, "j_fetch_pc");
    decode();
    s = '0;
    s.pc_write = 1'b1;
    s.pc_src   = 2'b10;
    step(s);
    push(K_PC, 5'd0, 32'h1000_0100, "jump_pc");
    drain();

    // Reserved PCSrc keeps PC.
    s.pc_src = 2'b11;
    step(s);
    push(K_PC, 5'd0, 32'h1000_0100, "pcsrc_reserved_pc");
    drain();

    // ori $14,$0,0x8001.
    alu_instr(32'h340E_8001, 1'b0, 3'b001, 5'd14, ORI_EXP, "ori_r14");

    // Reset mid-instruction with strobes active.
    fetch(32'h2008_0005);
    s = '0;
    s.alu_src_a = 1'b1;
    s.alu_src_b = 2'b10;
    s.alu_ctl   = 3'b010;
    s.reg_write = 1'b1;
    s.pc_write  = 1'b1;
    rst = 1'b1;
    step(s);
    rst = 1'b0;
    push(K_PC, 5'd0, 32'h0000_0100, "midreset_pc");
    push(K_OP, 5'd0, 32'd0, "midreset_op");
    push(K_REG, 5'd8, 32'd0, "midreset_r8");
    push(K_REG, 5'd10, 32'd0, "midreset_r10");
    push(K_REG, 5'd12, 32'd0, "midreset_r12");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
